// File: rtl/i2s_clk_gen_param_pkg.sv
// Shared types and helpers for the parametrised I2S/TDM clock generator.
package i2s_pkg;

  typedef enum logic [1:0] {I2S_STD, I2S_LJ, I2S_TDM, I2S_RSVD} i2s_mode_e;

  typedef enum {IDLE, RUN} i2s_gen_state_e;

  // Frame length in clk cycles for a given half-period; a half-period of 0 counts as 1.
  function automatic int unsigned frame_clks(input int unsigned half,
                                             input int unsigned slot_bits,
                                             input int unsigned num_slots);
    int unsigned h;
    h = (half == 0) ? 1 : half;
    return 2 * h * slot_bits * num_slots;
  endfunction

endpackage

// File: rtl/i2s_sclk_div.sv
// Half-period counter producing sclk_out and registered rise/fall strobes.
module i2s_sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] half,
  output logic             sclk_out,
  output logic             rise,
  output logic             fall,
  output logic             fall_tick
);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick      = run && (div_cnt == half - DIV_W'(1));
  // Combinational look-ahead so the frame counters advance on the same edge as the fall.
  assign fall_tick = tick && sclk_out;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt  <= '0;
      sclk_out <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= tick && !sclk_out;
      fall <= fall_tick;
      if (tick) begin
        div_cnt  <= '0;
        sclk_out <= !sclk_out;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_clk_gen_param.sv
// I2S / left-justified / TDM-pulse bit and frame clock generator with clk-domain strobes.
module i2s_clk_gen_param
  import i2s_pkg::*;
#(
  parameter  int DIV_W     = 8,
  parameter  int SLOT_BITS = 32,
  parameter  int NUM_SLOTS = 2,
  localparam int BIT_W     = $clog2(SLOT_BITS),
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_half,
  input  logic [1:0]        mode,
  output logic              sclk_out,
  output logic              ws_out,
  output logic              sclk_rise,
  output logic              sclk_fall,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              frame_start,
  output logic              busy,
  output i2s_gen_state_e    state
);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(NUM_SLOTS / 2);

  i2s_gen_state_e    state_q, state_d;
  logic [DIV_W-1:0]  half_q, half_in;
  i2s_mode_e         mode_q, eff_mode;
  logic              run, fall_tick, div_fall, launch_q;
  logic              last_bit, last_slot, wrap, launch, stop;
  logic [BIT_W-1:0]  bit_d;
  logic [SLOT_W-1:0] slot_d, slot_after;
  logic              ws_d;

  assign half_in   = (div_half == '0) ? DIV_W'(1) : div_half;
  assign run       = (state_q == RUN);
  assign last_bit  = (bit_idx == LAST_BIT);
  assign last_slot = (slot_idx == LAST_SLOT);
  assign wrap      = fall_tick && last_bit && last_slot;
  assign launch    = ((state_q == IDLE) && en) || (wrap && en);
  assign stop      = wrap && !en;

  i2s_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .half      (half_q),
    .sclk_out  (sclk_out),
    .rise      (sclk_rise),
    .fall      (div_fall),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)   state_d = RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    state     = state_q;
    // A fall registered on the stopping edge launches no bit, so it is masked in IDLE.
    sclk_fall = launch_q || (div_fall && run);
  end

  always_comb begin
    bit_d  = bit_idx;
    slot_d = slot_idx;
    if (launch) begin
      bit_d  = '0;
      slot_d = '0;
    end else if (fall_tick) begin
      if (last_bit) begin
        bit_d  = '0;
        slot_d = last_slot ? '0 : slot_idx + 1'b1;
      end else begin
        bit_d = bit_idx + 1'b1;
      end
    end
  end

  // I2S ws leads by one bit: it takes the slot of the bit after the one being launched.
  always_comb begin
    eff_mode   = launch ? i2s_mode_e'(mode) : mode_q;
    slot_after = slot_d;
    if (bit_d == LAST_BIT) slot_after = (slot_d == LAST_SLOT) ? '0 : slot_d + 1'b1;
    case (eff_mode)
      I2S_LJ:  ws_d = (slot_d >= HALF_SLOT);
      I2S_TDM: ws_d = (slot_d == '0) && (bit_d == '0);
      default: ws_d = (slot_after >= HALF_SLOT);
    endcase
    if (stop) ws_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx     <= '0;
      slot_idx    <= '0;
      ws_out      <= 1'b0;
      frame_start <= 1'b0;
      launch_q    <= 1'b0;
      half_q      <= DIV_W'(1);
      mode_q      <= I2S_STD;
    end else begin
      launch_q    <= (state_q == IDLE) && en;
      frame_start <= launch;
      bit_idx     <= bit_d;
      slot_idx    <= slot_d;
      if (launch || fall_tick) ws_out <= ws_d;
      if (launch) begin
        half_q <= half_in;
        mode_q <= i2s_mode_e'(mode);
      end
    end
  end

endmodule

// File: tb/tb_i2s_clk_gen_param.sv
// Bench for i2s_clk_gen_param: two configurations checked every cycle against a frame-time model.
module tb_i2s_clk_gen_param;
  import i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           en_a, en_b;
  logic [7:0]     div_a, div_b;
  logic [1:0]     mode_a, mode_b;
  logic           sclk_a, ws_a, rise_a, fall_a, fs_a, busy_a;
  logic           sclk_b, ws_b, rise_b, fall_b, fs_b, busy_b;
  logic [3:0]     bit_a;
  logic [0:0]     slot_a;
  logic [4:0]     bit_b;
  logic [2:0]     slot_b;
  i2s_gen_state_e state_a, state_b;

  i2s_clk_gen_param #(.DIV_W(8), .SLOT_BITS(16), .NUM_SLOTS(2)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .div_half(div_a), .mode(mode_a),
    .sclk_out(sclk_a), .ws_out(ws_a), .sclk_rise(rise_a), .sclk_fall(fall_a),
    .bit_idx(bit_a), .slot_idx(slot_a), .frame_start(fs_a), .busy(busy_a), .state(state_a)
  );

  i2s_clk_gen_param #(.DIV_W(8), .SLOT_BITS(32), .NUM_SLOTS(8)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .div_half(div_b), .mode(mode_b),
    .sclk_out(sclk_b), .ws_out(ws_b), .sclk_rise(rise_b), .sclk_fall(fall_b),
    .bit_idx(bit_b), .slot_idx(slot_b), .frame_start(fs_b), .busy(busy_b), .state(state_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit check_on = 1'b0;

  // Model: position t within the current frame, plus the half-period and mode latched for it.
  typedef struct {
    bit on;
    int t;
    int h;
    int mode;
  } mdl_t;

  mdl_t ma = '{0, 0, 1, 0};
  mdl_t mb = '{0, 0, 1, 0};

  // {sclk, ws, rise, fall, frame_start, busy, bit[7:0], slot[7:0]}
  function automatic logic [21:0] expect_out(input mdl_t m, input int sb, input int ns);
    int  b, p, slot, bit_i, nx;
    logic ws;
    if (!m.on) return '0;
    b     = m.t / (2 * m.h);
    p     = m.t % (2 * m.h);
    slot  = b / sb;
    bit_i = b % sb;
    case (m.mode)
      1:       ws = (slot >= ns / 2);
      2:       ws = (b == 0);
      default: begin
        nx = ((b + 1) % (sb * ns)) / sb;
        ws = (nx >= ns / 2);
      end
    endcase
    return {p >= m.h, ws, p == m.h, p == 0, m.t == 0, 1'b1, 8'(bit_i), 8'(slot)};
  endfunction

  function automatic mdl_t advance(input mdl_t m, input logic rst, input logic en,
                                   input logic [7:0] dh, input logic [1:0] md,
                                   input int sb, input int ns);
    if (rst) begin
      m.on = 0;
    end else if (!m.on) begin
      if (en) begin
        m.on = 1; m.t = 0; m.h = (dh == 0) ? 1 : int'(dh); m.mode = int'(md);
      end
    end else if (m.t == int'(frame_clks(m.h, sb, ns)) - 1) begin
      if (en) begin
        m.t = 0; m.h = (dh == 0) ? 1 : int'(dh); m.mode = int'(md);
      end else begin
        m.on = 0;
      end
    end else begin
      m.t++;
    end
    return m;
  endfunction

  task automatic cmp_out(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      cmp_out("model_a", {sclk_a, ws_a, rise_a, fall_a, fs_a, busy_a, 8'(bit_a), 8'(slot_a)},
              expect_out(ma, 16, 2));
      cmp_out("model_b", {sclk_b, ws_b, rise_b, fall_b, fs_b, busy_b, 8'(bit_b), 8'(slot_b)},
              expect_out(mb, 32, 8));
    end
    ma = advance(ma, reset, en_a, div_a, mode_a, 16, 2);
    mb = advance(mb, reset, en_b, div_b, mode_b, 32, 8);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return fs_a;
      1:       return rise_a;
      2:       return !busy_a;
      3:       return fs_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name, output int c);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sig(which)) break;
    end
    c = cyc;
    if (!sig(which)) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s cycle %0d: event not seen, required within 5000 cycles", name, cyc);
    end
  endtask

  initial begin
    int c0, f, c, r, b, ws_cnt, strobes;
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0;
    div_a = 8'd2; div_b = 8'd1; mode_a = 2'd0; mode_b = 2'd0;
    repeat (3) step();
    check_on = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("reset_state_a", int'(state_a), int'(IDLE));
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_sclk_a", int'(sclk_a), 0);
    chk("reset_ws_b", int'(ws_b), 0);

    // I2S, H=2: launch latency, ws lead in the last bit of each slot, 128-clk frame
    step(); mode_a = 2'd0; div_a = 8'd2; en_a = 1'b1; c0 = cyc;
    wait_for(0, "fs_first", f);
    chk("launch_latency", f - c0, 1);
    chk("launch_fall", int'(fall_a), 1);
    chk("launch_bit", int'(bit_a), 0);
    wait_for(1, "first_rise", r);
    chk("rise_latency", r - c0, 3);
    to_cycle(f + 59); chk("i2s_ws_before_lead", int'(ws_a), 0);
    to_cycle(f + 60); chk("i2s_ws_lead", int'(ws_a), 1); chk("i2s_lead_bit", int'(bit_a), 15);
    to_cycle(f + 123); chk("i2s_ws_slot1", int'(ws_a), 1);
    to_cycle(f + 124); chk("i2s_ws_fall", int'(ws_a), 0); chk("i2s_fall_slot", int'(slot_a), 1);
    wait_for(0, "fs_second", c); chk("i2s_frame_len", c - f, 128); f = c;

    // Left-justified: ws changes at slot 1 bit 0
    step(); mode_a = 2'd1;
    wait_for(0, "fs_lj", c); chk("lj_prev_frame_len", c - f, 128); f = c;
    to_cycle(f + 63); chk("lj_ws_before", int'(ws_a), 0);
    to_cycle(f + 64); chk("lj_ws_rise", int'(ws_a), 1); chk("lj_fall", int'(fall_a), 1);
    chk("lj_bit", int'(bit_a), 0); chk("lj_slot", int'(slot_a), 1);

    // div_half changes take effect only at the next frame; 0 acts as 1
    step(); mode_a = 2'd0; div_a = 8'd5;
    wait_for(0, "fs_div5", c); chk("old_period_kept", c - f, 128); f = c;
    to_cycle(f + 5); chk("h5_rise", int'(rise_a), 1);
    to_cycle(f + 10); chk("h5_fall", int'(fall_a), 1); chk("h5_bit", int'(bit_a), 1);
    step(); div_a = 8'd0;
    wait_for(0, "fs_div0", c); chk("h5_frame_len", c - f, 320); f = c;
    to_cycle(f + 1); chk("h1_rise", int'(rise_a), 1); chk("h1_sclk", int'(sclk_a), 1);
    to_cycle(f + 2); chk("h1_fall", int'(fall_a), 1); chk("h1_bit", int'(bit_a), 1);

    // en dropped mid-frame: frame completes, then relaunch one clk after busy falls
    step(); en_a = 1'b0;
    wait_for(2, "busy_fall", b);
    chk("stop_at_frame_end", b - f, 64);
    chk("idle_sclk", int'(sclk_a), 0); chk("idle_ws", int'(ws_a), 0); chk("idle_fs", int'(fs_a), 0);
    step(); en_a = 1'b1;
    wait_for(0, "fs_relaunch", c);
    chk("relaunch_latency", c - b, 2); chk("relaunch_bit", int'(bit_a), 0);
    chk("relaunch_fall", int'(fall_a), 1);

    // Reset mid-slot beats en
    to_cycle(c + 21);
    step(); reset = 1'b1;
    step(); reset = 1'b0; en_a = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy_a), 0); chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_bit", int'(bit_a), 0); chk("rst_state", int'(state_a), int'(IDLE));
    strobes = 0;
    repeat (20) begin
      @(negedge clk);
      strobes += int'(fall_a) + int'(rise_a) + int'(fs_a);
    end
    chk("no_strobes_after_reset", strobes, 0);

    // TDM pulse, 8 slots of 32 bits, H=1
    step(); mode_b = 2'd2; div_b = 8'd1; en_b = 1'b1;
    wait_for(3, "fs_tdm", f);
    ws_cnt = 0;
    for (int k = 0; k < 512; k++) begin
      to_cycle(f + k);
      ws_cnt += int'(ws_b);
      if (k == 0) chk("tdm_ws_at_fs", int'(ws_b), 1);
      if (k % 64 == 0) chk($sformatf("tdm_slot%0d", k / 64), int'(slot_b), k / 64);
    end
    chk("tdm_ws_width", ws_cnt, 2);
    wait_for(3, "fs_tdm2", c); chk("tdm_frame_len", c - f, 512);

    // Randomised enables, dividers, modes and occasional resets on both instances
    for (int i = 0; i < 12000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) en_a = ~en_a;
      if ($urandom_range(0, 1499) == 0) en_b = ~en_b;
      if ($urandom_range(0, 149) == 0) div_a = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 149) == 0) div_b = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) mode_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) mode_b = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 2999) == 0);
    end
    step(); reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
